systolic_array_nxn: RTL and testbench

Parametrised successor to the fixed 4x4 systolic array. It is an N x N output-stationary matrix-multiply engine with input skew buffers, a built-in control FSM, valid/ready streaming for operands and results, and a programmable reduction length K. It computes C = A x B, where A is N x K and B is K x N. It sits between the operand buffers (A and B feeders) and the result buffer, and replaces the external result_ld timing with a handshake.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_pe.sv | 62 ++++++
 rtl/systolic_array_nxn.sv | 148 ++++++++++++++
 tb/tb_systolic_array_nxn.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the N x N output-stationary systolic array.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READ  = 2'd3
  } sa_state_e;

  // Cycles needed for the last injected operand to cross the skewed grid.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Processing element: registered a/b pass-through and a signed MAC accumulator.
// Define SA_SATURATE_EN for sticky signed saturation instead of two's-complement wrap.
module systolic_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_nxt;

  assign prod     = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(b_in);
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef SA_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] sum_wide;
  logic               ovf;
  logic               sat;

  assign sum_wide = {acc[ACC_WIDTH-1], acc} + {prod_ext[ACC_WIDTH-1], prod_ext};
  assign ovf      = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];

  // Once clamped the accumulator freezes until the next job clears it.
  always_comb begin
    acc_nxt = sum_wide[ACC_WIDTH-1:0];
    if (sat) acc_nxt = acc;
    else if (ovf) acc_nxt = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) sat <= 1'b0;
    else if (ovf) sat <= 1'b1;
  end
`else
  assign acc_nxt = acc + prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary matrix-multiply engine with input skew, control FSM and
// valid/ready operand and result streams. SA_SATURATE_EN selects saturating PEs.
//
// state | meaning
// IDLE  | waiting for start; k_len latched and datapath cleared on start
// LOAD  | accepting operand beats until k_len beats have handshaken
// DRAIN | 2N-1 cycles of zero injection to flush the skewed grid
// READ  | presenting result rows 0..N-1, one per out_ready handshake
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      a_col,
  input  logic [N*DATA_WIDTH-1:0]      b_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*ACC_WIDTH-1:0]       out_row,
  output logic [$clog2(N)-1:0]         out_row_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int KW        = cnt_width(K_MAX);
  localparam int IW        = cnt_width(N - 1);
  localparam int DRAIN_LEN = drain_len(N);
  localparam int DCW       = cnt_width(DRAIN_LEN - 1);

  sa_state_e        state, state_nxt;
  logic [KW-1:0]    k_rem, k_eff;
  logic [DCW-1:0]   drain_cnt;
  logic [IW-1:0]    idx;
  logic             in_hs, clr_all, last_row_hs;
  logic [N*DATA_WIDTH-1:0] a_feed, b_feed;

  logic signed [DATA_WIDTH-1:0] a_h [N][N+1];
  logic signed [DATA_WIDTH-1:0] b_v [N+1][N];
  logic signed [ACC_WIDTH-1:0]  acc_g [N][N];
  logic [N-1:0]                 unused_edge;

  assign k_eff       = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign in_hs       = in_valid && in_ready;
  assign clr_all     = (state == IDLE) && start;
  assign last_row_hs = (state == READ) && out_ready && (idx == IW'(N - 1));
  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == READ);
  assign busy        = (state != IDLE);
  assign out_row_idx = idx;

  // Non-handshake cycles feed zeros so bubbles and drain never add to the sums.
  assign a_feed = in_hs ? a_col : '0;
  assign b_feed = in_hs ? b_row : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_eff == '0) ? DRAIN : LOAD;
      LOAD:    if (in_hs && k_rem == KW'(1)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = READ;
      READ:    if (last_row_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_rem     <= '0;
      drain_cnt <= '0;
      idx       <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_row_hs;
      if (clr_all) k_rem <= k_eff;
      else if (in_hs) k_rem <= k_rem - KW'(1);
      if (state_nxt == DRAIN && state != DRAIN) drain_cnt <= DCW'(DRAIN_LEN - 1);
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DCW'(1);
      if (clr_all) idx <= '0;
      else if (state == READ && out_ready) idx <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Row i of A and column i of B are delayed i cycles before entering the grid.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[i][0] = a_feed[DATA_WIDTH-1:0];
      assign b_v[0][i] = b_feed[DATA_WIDTH-1:0];
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] a_sr [i];
      logic signed [DATA_WIDTH-1:0] b_sr [i];
      always_ff @(posedge clk) begin
        if (rst || clr_all) begin
          for (int k = 0; k < i; k++) begin
            a_sr[k] <= '0;
            b_sr[k] <= '0;
          end
        end else begin
          a_sr[0] <= a_feed[i*DATA_WIDTH +: DATA_WIDTH];
          b_sr[0] <= b_feed[i*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < i; k++) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
          end
        end
      end
      assign a_h[i][0] = a_sr[i-1];
      assign b_v[0][i] = b_sr[i-1];
    end
    assign unused_edge[i] = ^{a_h[i][N], b_v[N][i]};
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_all),
        .a_in (a_h[i][j]),
        .b_in (b_v[i][j]),
        .a_out(a_h[i][j+1]),
        .b_out(b_v[i+1][j]),
        .acc  (acc_g[i][j])
      );
    end
  end

  always_comb begin
    out_row = '0;
    for (int j = 0; j < N; j++) out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_g[idx][j];
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed self-checking bench for systolic_array_nxn at N=4, 16-bit operands, 32-bit results.
module tb_systolic_array_nxn;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int K_MAX = 64;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int IW    = $clog2(N);

  logic            clk = 1'b0;
  logic            rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_col, b_row;
  logic [N*AW-1:0] out_row;
  logic [IW-1:0]   out_row_idx;

  logic signed [DW-1:0] a_m [N][K_MAX];
  logic signed [DW-1:0] b_m [K_MAX][N];
  int exp_c [N][N];
  int n_pass = 0, n_total = 0, done_cnt = 0;

  systolic_array_nxn #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_row(input string tag, input int r);
    check($sformatf("%s%0d_valid", tag, r), out_valid, 1);
    check($sformatf("%s%0d_idx", tag, r), out_row_idx, r);
    for (int j = 0; j < N; j++)
      check($sformatf("%s%0d_c%0d", tag, r, j), $signed(out_row[j*AW +: AW]), exp_c[r][j]);
  endtask

  task automatic fill_const(input int av, input int bv, input int ev);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K_MAX; k++) begin
        a_m[i][k] = DW'(av);
        b_m[k][i] = DW'(bv);
      end
      for (int j = 0; j < N; j++) exp_c[i][j] = ev;
    end
  endtask

  task automatic start_job(input int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int k, input bit bubbles, input int start_at);
    int beat = 0;
    int cyc = 0;
    bit on = 1'b1;
    while (beat < k && cyc < 1000) begin
      start    = (cyc == start_at);
      in_valid = on;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = on ? a_m[i][beat] : 16'h7fff;
        b_row[i*DW +: DW] = on ? b_m[beat][i] : 16'h7fff;
      end
      if (on && in_ready) beat++;
      @(negedge clk);
      cyc++;
      if (bubbles) on = !on;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("beats_accepted", beat, k);
  endtask

  task automatic read_rows(input int hold_row);
    int cnt = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 2 * N - 1);
    for (int r = 0; r < N; r++) begin
      if (r == hold_row) begin
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          check_row("hold", r);
        end
      end
      out_ready = 1'b1;
      check_row("row", r);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    @(negedge clk);
    check("done_single", done, 0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b1; k_len = KW'(4); in_valid = 1'b0; out_ready = 1'b0;
    a_col = '0; b_row = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, 0);
    check("rst_idx", out_row_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // identity A, B rows 1..16: C equals B
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        a_m[i][k] = (i == k) ? DW'(1) : DW'(0);
        b_m[k][i] = DW'(4 * k + i + 1);
      end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) exp_c[r][j] = 4 * r + j + 1;
    start_job(4);
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
    feed(4, 1'b0, -1);
    read_rows(-1);

    // all ones, bubbles every other cycle, stray start mid-load
    fill_const(1, 1, 8);
    start_job(8);
    feed(8, 1'b1, 3);
    read_rows(-1);

    // k_len = 0 with in_valid held high outside LOAD
    fill_const(0, 0, 0);
    in_valid = 1'b1;
    a_col = {N{16'h1234}};
    b_row = {N{16'h0f0f}};
    start_job(0);
    check("k0_in_ready", in_ready, 0);
    read_rows(-1);
    in_valid = 1'b0;

    // reset mid-drain aborts the job without a done pulse
    fill_const(2, 2, 16);
    start_job(4);
    feed(4, 1'b0, -1);
    repeat (2) @(negedge clk);
    dc = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_no_done", done_cnt, dc);

    // signed operands, row 1 held for 5 cycles
    fill_const(-3, 7, -105);
    start_job(5);
    feed(5, 1'b0, -1);
    read_rows(1);

    // overflow: 64 * 32767^2 = 68715282496
`ifdef SA_SATURATE_EN
    fill_const(32767, 32767, 2147483647);
`else
    fill_const(32767, 32767, -4194240);
`endif
    start_job(64);
    feed(64, 1'b0, -1);
    read_rows(-1);

    // k_len beyond K_MAX is clamped to 64 beats
    fill_const(1, 1, 64);
    start_job(127);
    feed(64, 1'b0, -1);
    read_rows(-1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
